rr_fifo_sched: RTL and testbench
================================

RR_FIFO_SCHED -- requirements
Module: rr_fifo_sched

Interface
REQ-001 SHALL have parameter NPORT, default 4, number of source FIFOs.
REQ-002 SHALL have parameter PWIDTH, default 2, log2(NPORT); must match NPORT.
REQ-003 SHALL have parameter DWIDTH, default 8, data width.
REQ-004 SHALL have parameter BURST, default 4, max consecutive transfers per grant, range 1..2^BWIDTH-1.
REQ-005 SHALL have parameter BWIDTH, default 3, burst counter width.
REQ-006 SHALL have port clk, input, 1, clock; all state on rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port src_rdy, input, NPORT, bit i high = source FIFO i non-empty.
REQ-009 SHALL have port src_dout, input, NPORT*DWIDTH, head data of FIFO i at bits [i*DWIDTH +: DWIDTH].
REQ-010 SHALL have port src_pop, output, NPORT, one-hot-or-zero pop strobe to source FIFOs.
REQ-011 SHALL have port dst_not_full, input, 1, destination can accept a word this cycle.
REQ-012 SHALL have port dst_push, output, 1, destination write strobe.
REQ-013 SHALL have port dst_din, output, DWIDTH, destination write data.
REQ-014 SHALL have port grant_valid, output, 1, a port currently owns the datapath.
REQ-015 SHALL have port grant_id, output, PWIDTH, index of owning port.
REQ-016 SHALL have port xfer_cnt, output, 16, total words transferred, wraps at 2^16.

Function
REQ-017 SHALL implement two states: IDLE (no owner) and SERVE (owner = grant_id).
REQ-018 SHALL hold a registered round-robin pointer last (index of most recent owner).
REQ-019 Arbitration SHALL select the first i with src_rdy[i]=1 searching last+1, last+2, ... wrapping modulo NPORT, last itself examined last.
REQ-020 In IDLE, if any src_rdy bit high, SHALL enter SERVE next cycle with owner = arbitration winner, bcnt=0, last=winner; else remain IDLE.
REQ-021 In IDLE, src_pop, dst_push SHALL be 0 (one-cycle arbitration latency).
REQ-022 In SERVE, xfer = src_rdy[owner] & dst_not_full, combinational.
REQ-023 On xfer, src_pop[owner]=1, dst_push=1, dst_din = src_dout slice of owner, same cycle; otherwise all src_pop=0, dst_push=0, dst_din don't-care.
REQ-024 src_pop SHALL never have more than one bit set.
REQ-025 On xfer with bcnt < BURST-1, SHALL stay in SERVE with same owner, bcnt+1.
REQ-026 On xfer with bcnt == BURST-1, SHALL re-arbitrate (REQ-019, current src_rdy values); winner -> SERVE, bcnt=0, last=winner; no requester -> IDLE.
REQ-027 In SERVE with src_rdy[owner]=0, SHALL re-arbitrate per REQ-026 with no transfer that cycle.
REQ-028 In SERVE with src_rdy[owner]=1 and dst_not_full=0, SHALL hold owner and bcnt (stall, no timeout).
REQ-029 Re-arbitration when only the owner requests SHALL re-grant the owner with bcnt=0.
REQ-030 grant_valid SHALL equal (state==SERVE); grant_id = owner, 0 in IDLE.
REQ-031 xfer_cnt SHALL increment by 1 on every cycle with dst_push=1, wrap 0xFFFF -> 0.
REQ-032 src_rdy and dst_not_full SHALL carry no combinational dependency on src_pop or dst_push; this block adds no path from them to itself beyond REQ-022/023.

Reset
REQ-033 While reset=1, state=IDLE, last=NPORT-1 (port 0 wins first), bcnt=0, xfer_cnt=0, grant_valid=0, grant_id=0.
REQ-034 Reset assertion mid-SERVE SHALL force src_pop=0 and dst_push=0 immediately, without waiting for clk.
REQ-035 First arbitration after reset release SHALL occur on the first rising edge with reset=0.

Verification
REQ-036 After reset, src_rdy=4'b0101, dst_not_full=1 -> cycle 1 grant_id=0, port 0 transfers 4 words (BURST=4), then grant_id=2, no idle cycle between grants.
REQ-037 Only port 3 ready with 10 words, dst_not_full=1 -> bursts 4,4,2 with re-grant to 3 and no bubble; src_rdy[3] falls -> IDLE; xfer_cnt=10.
REQ-038 Port 1 owner, dst_not_full=0 for 5 cycles mid-burst -> src_pop=0, dst_push=0, grant_id=1, bcnt held; burst completes with exactly 4 words total.
REQ-039 All four ports continuously ready -> grant order 0,1,2,3,0..., each burst 4 words, src_pop always one-hot on push cycles, dst_din matches owner slice.
REQ-040 Assert reset during burst (src_pop[2]=1) -> src_pop=0, dst_push=0 same cycle; after release port 0 granted first, xfer_cnt=0.
REQ-041 Run 65537 transfers -> xfer_cnt wraps to 1.

Source files
------------

// File: rtl/rr_fifo_sched.sv
// Round-robin scheduler draining NPORT source FIFOs into one destination.
// Grants are held for up to BURST words; ownership moves round-robin
// starting after the most recent owner. The owner loses its grant early
// if its FIFO runs dry. Destination backpressure stalls the grant in
// place, with no timeout.
module rr_fifo_sched #(
  parameter int NPORT  = 4,
  parameter int PWIDTH = 2,
  parameter int DWIDTH = 8,
  parameter int BURST  = 4,
  parameter int BWIDTH = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NPORT-1:0]        src_rdy,
  input  logic [NPORT*DWIDTH-1:0] src_dout,
  output logic [NPORT-1:0]        src_pop,
  input  logic                    dst_not_full,
  output logic                    dst_push,
  output logic [DWIDTH-1:0]       dst_din,
  output logic                    grant_valid,
  output logic [PWIDTH-1:0]       grant_id,
  output logic [15:0]             xfer_cnt
);

  typedef enum logic {IDLE, SERVE} state_t;

  state_t              state_q, state_d;
  logic [PWIDTH-1:0]   owner_q, owner_d;
  logic [PWIDTH-1:0]   last_q, last_d;
  logic [BWIDTH-1:0]   bcnt_q, bcnt_d;
  logic [15:0]         xfer_cnt_q;

  logic                arb_found;
  logic [PWIDTH-1:0]   arb_win;
  logic [PWIDTH-1:0]   cand;
  logic                xfer;
  logic                rearb;

  // Round-robin search: last+1, last+2, ... with last itself checked last
  always_comb begin
    arb_found = 1'b0;
    arb_win   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NPORT; k++) begin
      cand = PWIDTH'((32'(last_q) + k + 1) % NPORT);
      if (!arb_found && src_rdy[cand]) begin
        arb_found = 1'b1;
        arb_win   = cand;
      end
    end
  end

  // A word moves only when the owner has data and the destination has room
  assign xfer = (state_q == SERVE) && src_rdy[owner_q] && dst_not_full;

  // Datapath strobes and data mux for the current owner
  always_comb begin
    src_pop = '0;
    dst_din = '0;
    for (int unsigned i = 0; i < NPORT; i++) begin
      if (owner_q == PWIDTH'(i)) begin
        src_pop[i] = xfer;
        dst_din    = src_dout[i*DWIDTH +: DWIDTH];
      end
    end
  end

  assign dst_push    = xfer;
  assign grant_valid = (state_q == SERVE);
  assign grant_id    = (state_q == SERVE) ? owner_q : '0;
  assign xfer_cnt    = xfer_cnt_q;

  // Next-state: burst accounting, stall hold and re-arbitration
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    bcnt_d  = bcnt_q;
    rearb   = 1'b0;
    case (state_q)
      IDLE: rearb = 1'b1;
      SERVE: begin
        if (!src_rdy[owner_q]) begin
          rearb = 1'b1;
        end else if (dst_not_full) begin
          if (bcnt_q == BWIDTH'(BURST - 1)) begin
            rearb = 1'b1;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (rearb) begin
      if (arb_found) begin
        state_d = SERVE;
        owner_d = arb_win;
        last_d  = arb_win;
        bcnt_d  = '0;
      end else begin
        state_d = IDLE;
        owner_d = '0;
        bcnt_d  = '0;
      end
    end
  end

  // State registers; async reset parks on IDLE so port 0 wins first
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      last_q     <= PWIDTH'(NPORT - 1);
      bcnt_q     <= '0;
      xfer_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      bcnt_q  <= bcnt_d;
      if (dst_push) xfer_cnt_q <= xfer_cnt_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_rr_fifo_sched.sv
// Directed bench for rr_fifo_sched: source FIFOs are modelled as word
// counters, and expected words are queued per scenario in grant order.
module tb_rr_fifo_sched;

  logic        clk;
  logic        reset;
  logic [3:0]  src_rdy;
  logic [31:0] src_dout;
  logic [3:0]  src_pop;
  logic        dst_not_full;
  logic        dst_push;
  logic [7:0]  dst_din;
  logic        grant_valid;
  logic [1:0]  grant_id;
  logic [15:0] xfer_cnt;

  rr_fifo_sched #(
    .NPORT(4), .PWIDTH(2), .DWIDTH(8), .BURST(4), .BWIDTH(3)
  ) dut (
    .clk(clk), .reset(reset), .src_rdy(src_rdy), .src_dout(src_dout),
    .src_pop(src_pop), .dst_not_full(dst_not_full), .dst_push(dst_push),
    .dst_din(dst_din), .grant_valid(grant_valid), .grant_id(grant_id),
    .xfer_cnt(xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;
  int unsigned cnt [4];
  int unsigned seq [4];
  int unsigned exp_seq [4];
  logic [7:0]  exp_q [$];
  logic [15:0] xmodel;
  logic        nf;
  int unsigned npush, first_cyc, last_cyc, rel;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_words(input int unsigned p, input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      exp_q.push_back({2'(p), 6'(exp_seq[p])});
      exp_seq[p]++;
    end
  endtask

  task automatic clear_stats();
    npush = 0; first_cyc = 0; last_cyc = 0;
  endtask

  task automatic step();
    logic [7:0] e;
    logic [3:0] exp_pop;
    @(negedge clk);
    cyc++;
    for (int unsigned i = 0; i < 4; i++) begin
      src_rdy[i] = (cnt[i] != 0);
      src_dout[i*8 +: 8] = {2'(i), 6'(seq[i])};
    end
    dst_not_full = nf;
    #1;
    chk("xfer_cnt", xfer_cnt, xmodel);
    if (reset) begin
      chk("rst_grant_valid", grant_valid, 0);
      chk("rst_grant_id", grant_id, 0);
      chk("rst_push", dst_push, 0);
    end
    if (dst_push) begin
      chk("push_has_expect", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        exp_pop = 4'b0001 << e[7:6];
        chk("dst_din", dst_din, e);
        chk("grant_id", grant_id, e[7:6]);
        chk("src_pop_onehot", src_pop, exp_pop);
        chk("grant_valid", grant_valid, 1);
      end
      if (npush == 0) first_cyc = cyc;
      last_cyc = cyc;
      npush++;
      xmodel++;
    end else begin
      chk("src_pop_quiet", src_pop, 0);
      if (!grant_valid) chk("grant_id_idle", grant_id, 0);
    end
    for (int unsigned i = 0; i < 4; i++) begin
      if (src_pop[i]) begin
        cnt[i]--;
        seq[i]++;
      end
    end
  endtask

  task automatic run(input int unsigned budget);
    int unsigned n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) step();
    chk("idle_grant_valid", grant_valid, 0);
  endtask

  task automatic steps_until_pushes(input int unsigned want, input int unsigned budget);
    int unsigned n;
    n = 0;
    while (npush < want && n < budget) begin
      step();
      n++;
    end
  endtask

  initial begin
    reset = 1'b1; nf = 1'b1; xmodel = '0;
    src_rdy = '0; src_dout = '0; dst_not_full = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      cnt[i] = 0; seq[i] = 0; exp_seq[i] = 0;
    end
    clear_stats();
    repeat (3) step();

    // Ports 0 and 2 ready: 0 wins first, bursts alternate with no gap
    cnt[0] = 8; cnt[2] = 8;
    step(); step();
    expect_words(0, 4); expect_words(2, 4); expect_words(0, 4); expect_words(2, 4);
    clear_stats(); rel = cyc;
    reset = 1'b0;
    #1;
    chk("s1_idle_latency", dst_push, 0);
    chk("s1_idle_gv", grant_valid, 0);
    run(40);
    chk("s1_first_cycle", first_cyc - rel, 1);
    chk("s1_span", last_cyc - first_cyc + 1, 16);
    chk("s1_words", npush, 16);
    idle(3);

    // Only port 3 with 10 words: bursts 4,4,2 back to back
    reset = 1'b1; xmodel = '0;
    #1;
    chk("s2_rst_cnt", xfer_cnt, 0);
    cnt[3] = 10;
    step(); step();
    expect_words(3, 10);
    clear_stats(); rel = cyc;
    reset = 1'b0;
    run(40);
    chk("s2_first_cycle", first_cyc - rel, 1);
    chk("s2_span", last_cyc - first_cyc + 1, 10);
    idle(3);
    chk("s2_total", xfer_cnt, 10);

    // Port 1 stalled mid-burst; burst count must survive the stall
    cnt[1] = 6; cnt[2] = 2;
    expect_words(1, 4); expect_words(2, 2); expect_words(1, 2);
    clear_stats();
    steps_until_pushes(2, 10);
    chk("s3_pre_stall", npush, 2);
    nf = 1'b0;
    repeat (5) begin
      step();
      chk("s3_stall_push", dst_push, 0);
      chk("s3_stall_pop", src_pop, 0);
      chk("s3_stall_gv", grant_valid, 1);
      chk("s3_stall_gid", grant_id, 1);
    end
    nf = 1'b1;
    run(30);
    chk("s3_words", npush, 8);
    idle(3);

    // All four ports ready: grant order 0,1,2,3,0,1,2,3
    reset = 1'b1; xmodel = '0;
    #1;
    for (int unsigned i = 0; i < 4; i++) cnt[i] = 8;
    step(); step();
    for (int unsigned r = 0; r < 2; r++)
      for (int unsigned p = 0; p < 4; p++) expect_words(p, 4);
    clear_stats(); rel = cyc;
    reset = 1'b0;
    run(80);
    chk("s4_first_cycle", first_cyc - rel, 1);
    chk("s4_span", last_cyc - first_cyc + 1, 32);
    idle(3);

    // Reset lands mid-burst of port 2: strobes drop before any clock
    cnt[2] = 8;
    expect_words(2, 4);
    clear_stats();
    steps_until_pushes(2, 10);
    chk("s5_pre", npush, 2);
    chk("s5_pop_before", src_pop, 4'b0100);
    reset = 1'b1; xmodel = '0;
    #1;
    chk("s5_async_pop", src_pop, 0);
    chk("s5_async_push", dst_push, 0);
    chk("s5_async_gv", grant_valid, 0);
    chk("s5_async_cnt", xfer_cnt, 0);
    exp_q.delete();
    for (int unsigned i = 0; i < 4; i++) exp_seq[i] = seq[i];
    step();
    cnt[0] = 2;
    step();
    expect_words(0, 2); expect_words(2, 6);
    clear_stats(); rel = cyc;
    reset = 1'b0;
    run(40);
    chk("s5_first_cycle", first_cyc - rel, 1);
    chk("s5_words", npush, 8);
    idle(3);
    chk("s5_xfer_cnt", xfer_cnt, 8);

    // 65537 transfers: counter wraps to 1
    reset = 1'b1; xmodel = '0;
    #1;
    cnt[0] = 65537;
    step();
    expect_words(0, 65537);
    clear_stats();
    reset = 1'b0;
    run(70000);
    chk("s6_words", npush, 65537);
    idle(3);
    chk("s6_wrap", xfer_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
